// File: rtl/correlate.sv
// ---------------------------------------------------------------------------
// correlate -- single-baseline complex correlator for 1-bit quantised I/Q.
//
// Each qualified sample contributes the complex product a * conj(b), where a
// bit value of 1 means +1 and 0 means -1. Terms are summed over a window
// delimited by first_i / last_i. One clock after the last sample the finished
// window sum appears on rdata_o / idata_o together with a one-cycle valid_o
// strobe. The result registers hold until the next window closes.
//
// Build option:
//   CORRELATE_SATURATE_EN  defined   -> each accumulate step clamps to
//                                       [-2^(WIDTH-1), 2^(WIDTH-1)-1]
//                          undefined -> wrap-around two's-complement sums
//
// Parameters:
//   WIDTH    accumulator and result width (signed two's complement, >= 3)
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   valid_i  in   sample qualifier; every other input is ignored when low
//   first_i  in   first sample of a window
//   last_i   in   last sample of a window
//   auto_i   in   auto-correlation: use a in place of b for this sample
//   ai_i     in   signal A in-phase bit
//   aq_i     in   signal A quadrature bit
//   bi_i     in   signal B in-phase bit
//   bq_i     in   signal B quadrature bit
//   frame_o  out  window accumulation in progress
//   valid_o  out  one-cycle strobe, rdata_o/idata_o hold a finished window
//   rdata_o  out  signed real part of the window sum
//   idata_o  out  signed imaginary part of the window sum
// ---------------------------------------------------------------------------
module correlate #(
    parameter int WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    valid_i,
    input  logic                    first_i,
    input  logic                    last_i,
    input  logic                    auto_i,
    input  logic                    ai_i,
    input  logic                    aq_i,
    input  logic                    bi_i,
    input  logic                    bq_i,
    output logic                    frame_o,
    output logic                    valid_o,
    output logic signed [WIDTH-1:0] rdata_o,
    output logic signed [WIDTH-1:0] idata_o
);

    localparam logic signed [WIDTH-1:0] POS2 = WIDTH'(2);
    localparam logic signed [WIDTH-1:0] NEG2 = WIDTH'(-2);
    localparam logic signed [WIDTH-1:0] ZERO = '0;

    // One accumulate step. A window start is expressed as a step from zero,
    // so loading and adding share the same (optionally saturating) adder.
    function automatic logic signed [WIDTH-1:0] acc_step(
        input logic signed [WIDTH-1:0] base,
        input logic signed [WIDTH-1:0] term
    );
`ifdef CORRELATE_SATURATE_EN
        logic signed [WIDTH:0] sum;
        sum = $signed({base[WIDTH-1], base}) + $signed({term[WIDTH-1], term});
        // The two top bits disagree only when the true sum left the range;
        // the top bit then tells the direction of the overflow.
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            if (sum[WIDTH]) begin
                return {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                return {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
        return sum[WIDTH-1:0];
`else
        return base + term;
`endif
    endfunction

    logic                    bi_eff;
    logic                    bq_eff;
    logic signed [WIDTH-1:0] term_re;
    logic signed [WIDTH-1:0] term_im;
    logic                    take;
    logic                    start;
    logic                    close;

    logic signed [WIDTH-1:0] acc_re_q, acc_re_d;
    logic signed [WIDTH-1:0] acc_im_q, acc_im_d;
    logic signed [WIDTH-1:0] rdata_q,  rdata_d;
    logic signed [WIDTH-1:0] idata_q,  idata_d;
    logic                    valid_q,  valid_d;
    logic                    frame_q,  frame_d;

    assign take  = valid_i;
    assign start = valid_i & first_i;
    assign close = valid_i & last_i;

    assign bi_eff = auto_i ? ai_i : bi_i;
    assign bq_eff = auto_i ? aq_i : bq_i;

    // With +/-1 samples each product is +1 when the bits agree and -1 when
    // they differ, so the terms reduce to bit-equality tests:
    //   re = ai*bi + aq*bq : +2 both agree, -2 both differ, else 0
    //   im = aq*bi - ai*bq : +2 only first agrees, -2 only second, else 0
    always_comb begin
        term_re = ZERO;
        term_im = ZERO;
        unique case ({ai_i == bi_eff, aq_i == bq_eff})
            2'b11:   term_re = POS2;
            2'b00:   term_re = NEG2;
            default: term_re = ZERO;
        endcase
        unique case ({aq_i == bi_eff, ai_i == bq_eff})
            2'b10:   term_im = POS2;
            2'b01:   term_im = NEG2;
            default: term_im = ZERO;
        endcase
    end

    always_comb begin
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        rdata_d  = rdata_q;
        idata_d  = idata_q;
        valid_d  = 1'b0;
        frame_d  = frame_q;

        if (take) begin
            acc_re_d = acc_step(start ? ZERO : acc_re_q, term_re);
            acc_im_d = acc_step(start ? ZERO : acc_im_q, term_im);
        end

        // The published result includes the closing sample's own term.
        if (close) begin
            rdata_d = acc_re_d;
            idata_d = acc_im_d;
            valid_d = 1'b1;
        end

        // A start wins over a close so a single-sample window, or a new
        // window opened on its own closing sample, keeps the frame up.
        if (start) begin
            frame_d = 1'b1;
        end else if (close) begin
            frame_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
            rdata_q  <= '0;
            idata_q  <= '0;
            valid_q  <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            rdata_q  <= rdata_d;
            idata_q  <= idata_d;
            valid_q  <= valid_d;
            frame_q  <= frame_d;
        end
    end

    assign frame_o = frame_q;
    assign valid_o = valid_q;
    assign rdata_o = rdata_q;
    assign idata_o = idata_q;

endmodule

// File: tb/tb_correlate.sv
module tb_correlate;

    localparam int WIDTH = 4;
`ifdef CORRELATE_SATURATE_EN
    localparam int OVF = 7;
`else
    localparam int OVF = -8;
`endif

    logic clock;
    logic reset;
    logic valid_i, first_i, last_i, auto_i;
    logic ai_i, aq_i, bi_i, bq_i;
    logic frame_o, valid_o;
    logic signed [WIDTH-1:0] rdata_o, idata_o;

    correlate #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .valid_i (valid_i),
        .first_i (first_i),
        .last_i  (last_i),
        .auto_i  (auto_i),
        .ai_i    (ai_i),
        .aq_i    (aq_i),
        .bi_i    (bi_i),
        .bq_i    (bq_i),
        .frame_o (frame_o),
        .valid_o (valid_o),
        .rdata_o (rdata_o),
        .idata_o (idata_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Reference model: window sums held as plain integers over +/-1 samples,
    // reduced to WIDTH bits (wrap or clamp) after every step.
    int m_acc_r, m_acc_i, m_out_r, m_out_i;
    int m_valid, m_frame;

    function automatic int fit(input int x);
        int lo, hi, span, y;
        lo   = -(1 << (WIDTH - 1));
        hi   = (1 << (WIDTH - 1)) - 1;
        span = 1 << WIDTH;
`ifdef CORRELATE_SATURATE_EN
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
`else
        y = ((x - lo) % span + span) % span;
        return y + lo;
`endif
    endfunction

    task automatic model_step();
        int a_i, a_q, b_i, b_q, tr, ti;
        if (reset) begin
            m_acc_r = 0; m_acc_i = 0; m_out_r = 0; m_out_i = 0;
            m_valid = 0; m_frame = 0;
            return;
        end
        m_valid = 0;
        if (valid_i) begin
            a_i = ai_i ? 1 : -1;
            a_q = aq_i ? 1 : -1;
            b_i = auto_i ? a_i : (bi_i ? 1 : -1);
            b_q = auto_i ? a_q : (bq_i ? 1 : -1);
            tr = a_i * b_i + a_q * b_q;
            ti = a_q * b_i - a_i * b_q;
            m_acc_r = fit(first_i ? tr : m_acc_r + tr);
            m_acc_i = fit(first_i ? ti : m_acc_i + ti);
            if (first_i) m_frame = 1;
            else if (last_i) m_frame = 0;
            if (last_i) begin
                m_valid = 1;
                m_out_r = m_acc_r;
                m_out_i = m_acc_i;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, and step past the edge.
    task automatic apply(input logic r, input logic v, input logic f, input logic l,
                         input logic a, input logic xai, input logic xaq,
                         input logic xbi, input logic xbq);
        reset = r; valid_i = v; first_i = f; last_i = l; auto_i = a;
        ai_i = xai; aq_i = xaq; bi_i = xbi; bq_i = xbq;
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string tag, input int ev, input int er,
                              input int ei, input int ef);
        check({tag, ".valid_o"}, int'(valid_o), ev);
        check({tag, ".rdata_o"}, int'(rdata_o), er);
        check({tag, ".idata_o"}, int'(idata_o), ei);
        check({tag, ".frame_o"}, int'(frame_o), ef);
    endtask

    typedef struct {
        logic v, f, l, a, ai, aq, bi, bq;
        int   ev, er, ei, ef;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic f, input logic l, input logic a,
                       input logic xai, input logic xaq, input logic xbi, input logic xbq,
                       input int ev, input int er, input int ei, input int ef);
        vec_t t;
        t.v = v; t.f = f; t.l = l; t.a = a;
        t.ai = xai; t.aq = xaq; t.bi = xbi; t.bq = xbq;
        t.ev = ev; t.er = er; t.ei = ei; t.ef = ef;
        tbl.push_back(t);
    endtask

    initial begin
        // all-match window of 3
        add(1,1,0,0, 1,1,1,1, 0, 0,0,1);
        add(1,0,0,0, 1,1,1,1, 0, 0,0,1);
        add(1,0,1,0, 1,1,1,1, 1, 6,0,0);
        add(0,0,0,0, 0,0,0,0, 0, 6,0,0);
        // single-sample window, b=(1,0)
        add(1,1,1,0, 1,1,1,0, 1, 0,2,1);
        add(0,0,0,0, 0,0,0,0, 0, 0,2,1);
        // all-anti window
        add(1,1,0,0, 1,1,0,0, 0, 0,2,1);
        add(1,0,0,0, 1,1,0,0, 0, 0,2,1);
        add(1,0,1,0, 1,1,0,0, 1,-6,0,0);
        // same with auto: b ignored
        add(1,1,0,1, 1,1,0,0, 0,-6,0,1);
        add(1,0,0,1, 1,1,0,1, 0,-6,0,1);
        add(1,0,1,1, 1,1,1,0, 1, 6,0,0);
        // window with 2-cycle valid gaps; gap inputs must be ignored
        add(1,1,0,0, 1,1,1,1, 0, 6,0,1);
        add(0,1,1,0, 0,1,0,1, 0, 6,0,1);
        add(0,0,1,1, 1,0,1,0, 0, 6,0,1);
        add(1,0,0,0, 1,1,1,0, 0, 6,0,1);
        add(0,1,0,0, 0,0,1,1, 0, 6,0,1);
        add(0,0,1,0, 1,1,0,0, 0, 6,0,1);
        add(1,0,1,0, 1,1,1,1, 1, 4,2,0);
        add(0,0,0,0, 1,0,1,0, 0, 4,2,0);
        // back-to-back: match then anti
        add(1,1,0,0, 1,1,1,1, 0, 4,2,1);
        add(1,0,0,0, 1,1,1,1, 0, 4,2,1);
        add(1,0,1,0, 1,1,1,1, 1, 6,0,0);
        add(1,1,0,0, 1,1,0,0, 0, 6,0,1);
        add(1,0,0,0, 1,1,0,0, 0, 6,0,1);
        add(1,0,1,0, 1,1,0,0, 1,-6,0,0);
        // 4-sample all-match: overflow
        add(1,1,0,0, 1,1,1,1, 0,-6,0,1);
        add(1,0,0,0, 1,1,1,1, 0,-6,0,1);
        add(1,0,0,0, 1,1,1,1, 0,-6,0,1);
        add(1,0,1,0, 1,1,1,1, 1,OVF,0,0);
        add(0,0,0,0, 0,0,0,0, 0,OVF,0,0);

        // reset state
        apply(1, 0,0,0,0, 0,0,0,0);
        apply(1, 0,0,0,0, 0,0,0,0);
        check_outs("reset", 0, 0, 0, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            apply(0, tbl[k].v, tbl[k].f, tbl[k].l, tbl[k].a,
                  tbl[k].ai, tbl[k].aq, tbl[k].bi, tbl[k].bq);
            check_outs($sformatf("vec%0d", k), tbl[k].ev, tbl[k].er, tbl[k].ei, tbl[k].ef);
        end

        // reset in the middle of a window discards it; a later last_i with
        // no first_i adds onto the cleared accumulator
        apply(0, 1,1,0,0, 1,1,1,1);
        check_outs("midrst.open", 0, OVF, 0, 1);
        apply(0, 1,0,0,0, 1,1,1,1);
        apply(1, 1,0,1,0, 1,1,1,1);
        check_outs("midrst.rst", 0, 0, 0, 0);
        apply(0, 0,0,0,0, 0,0,0,0);
        check_outs("midrst.idle", 0, 0, 0, 0);
        apply(0, 1,0,1,0, 1,1,1,1);
        check_outs("midrst.last", 1, 2, 0, 0);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            apply(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 9) < 2),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            check_outs($sformatf("rnd%0d", c), m_valid, m_out_r, m_out_i, m_frame);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
